// File: rtl/alu_arbiter.sv
//------------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. Port 0 is the
// execute stage, port 1 the address/branch helper. One operation may be in
// flight at a time. Ties are broken round-robin.
//
// Operation flow: IDLE (accept) -> EXEC (ALU evaluates the registered
// operands) -> RESP (result held until the owner takes it) -> IDLE.
//
// Ports
//   clk, rst_n                       clock (rising edge), synchronous active-low reset
//   reqN_valid / reqN_ready          request handshake for requester N
//   reqN_fn / reqN_funct7            ALU function and funct7 qualifier
//   reqN_a / reqN_b                  operands
//   rspN_valid / rspN_ready          response handshake for requester N
//   rspN_data                        result
//   alu_fn / alu_funct7 / alu_a / alu_b   registered drive to the ALU
//   alu_out                          combinational result from the ALU
//------------------------------------------------------------------------------

package alu_arbiter_pkg;

  typedef enum logic [2:0] {
    ADD_SUB = 3'd0,
    SLL     = 3'd1,
    SLT     = 3'd2,
    SLTU    = 3'd3,
    XOR     = 3'd4,
    SRL_SRA = 3'd5,
    OR      = 3'd6,
    AND     = 3'd7
  } alu_fn_t;

  typedef logic [6:0] funct7_t;

  localparam funct7_t F7_BASE = 7'b000_0000;
  localparam funct7_t SUB_SRA = 7'b010_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

//------------------------------------------------------------------------------
// alu_arbiter_checker
//
// Protocol properties of the arbiter, observed at its ports.
//   clk, rst_n        clock and synchronous reset
//   reqN_ready        request accepts
//   rspN_valid/ready  response handshake
//   rspN_data         response data
//------------------------------------------------------------------------------
module alu_arbiter_checker #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  input logic             req0_ready,
  input logic             req1_ready,
  input logic             rsp0_valid,
  input logic             rsp0_ready,
  input logic [WIDTH-1:0] rsp0_data,
  input logic             rsp1_valid,
  input logic             rsp1_ready,
  input logic [WIDTH-1:0] rsp1_data
);

  a_ready_exclusive: assert property (@(posedge clk) !(req0_ready && req1_ready));

  a_rsp_exclusive: assert property (@(posedge clk) !(rsp0_valid && rsp1_valid));

  a_no_accept_in_resp: assert property (@(posedge clk)
    (rsp0_valid || rsp1_valid) |-> !(req0_ready || req1_ready));

  a_rsp0_hold: assert property (@(posedge clk)
    (rst_n && rsp0_valid && !rsp0_ready) |=> (rsp0_valid && $stable(rsp0_data)));

  a_rsp1_hold: assert property (@(posedge clk)
    (rst_n && rsp1_valid && !rsp1_ready) |=> (rsp1_valid && $stable(rsp1_data)));

endmodule

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  alu_fn_t          req0_fn,
  input  funct7_t          req0_funct7,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  alu_fn_t          req1_fn,
  input  funct7_t          req1_funct7,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  // responses
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  // ALU interface
  output alu_fn_t          alu_fn,
  output funct7_t          alu_funct7,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  // Shift functions only honour the low SHAMT_W bits of b; clear the rest so
  // the ALU never sees an out-of-range shift amount.
  function automatic logic [WIDTH-1:0] shift_mask_b(input alu_fn_t fn,
                                                    input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] m;
    m = '0;
    if (fn == SLL || fn == SRL_SRA) begin
      m[SHAMT_W-1:0] = b[SHAMT_W-1:0];
    end else begin
      m = b;
    end
    return m;
  endfunction

  arb_state_t       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  alu_fn_t          alu_fn_q, alu_fn_d;
  funct7_t          alu_funct7_q, alu_funct7_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             any_valid_s;
  logic             grant_s;
  logic             accept_s;
  logic             rsp_take_s;
  alu_fn_t          sel_fn_s;
  funct7_t          sel_f7_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;

  assign any_valid_s = req0_valid | req1_valid;

  // Round-robin grant: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant_s = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grant_s = 1'b1;
    end else if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Payload of the granted requester.
  always_comb begin
    sel_fn_s = req0_fn;
    sel_f7_s = req0_funct7;
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    if (grant_s) begin
      sel_fn_s = req1_fn;
      sel_f7_s = req1_funct7;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_fn_s = req0_fn;
      sel_f7_s = req0_funct7;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_take_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: request readies only in IDLE (and never during reset),
  // response valid only for the owner in RESP.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && any_valid_s) begin
          req0_ready = ~grant_s;
          req1_ready = grant_s;
        end else begin
          req0_ready = 1'b0;
          req1_ready = 1'b0;
        end
      end
      ST_EXEC: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
      ST_RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
      end
    endcase
  end

  assign accept_s   = req0_ready | req1_ready;
  assign rsp_take_s = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  // Datapath next state: latch the granted op on accept, capture the ALU result in EXEC.
  always_comb begin
    alu_fn_d     = alu_fn_q;
    alu_funct7_d = alu_funct7_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    if (accept_s) begin
      alu_fn_d     = sel_fn_s;
      alu_funct7_d = sel_f7_s;
      alu_a_d      = sel_a_s;
      alu_b_d      = shift_mask_b(sel_fn_s, sel_b_s);
      owner_d      = grant_s;
      last_grant_d = grant_s;
    end else begin
      alu_fn_d     = alu_fn_q;
      alu_funct7_d = alu_funct7_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
    end
    if (state_q == ST_EXEC) begin
      result_d = alu_out;
    end else begin
      result_d = result_q;
    end
  end

  // Datapath registers. last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_fn_q     <= ADD_SUB;
      alu_funct7_q <= F7_BASE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      alu_fn_q     <= alu_fn_d;
      alu_funct7_q <= alu_funct7_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end

  assign alu_fn     = alu_fn_q;
  assign alu_funct7 = alu_funct7_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;

  alu_arbiter_checker #(.WIDTH(WIDTH)) u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data)
  );

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- At most one operation is outstanding. Round-robin arbitration selects the requester.
- The block registers operands into the ALU, captures the result and returns it to the granted requester.

Parameters:
- WIDTH, 32, datapath width of operands and result; must be a power of two ≥ 4.
- SHAMT_W, $clog2(WIDTH), number of low bits of b used as shift amount.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_fn  in  alu_fn_t  ALU function
- req0_funct7  in  funct7_t  funct7 qualifier (SUB_SRA selects sub/arith shift)
- req0_a, req0_b  in  WIDTH  operands
- req1_valid / req1_ready / req1_fn / req1_funct7 / req1_a / req1_b  same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp0_data  out  WIDTH  result
- rsp1_valid / rsp1_ready / rsp1_data  same as requester 0, for requester 1
- alu_fn  out  alu_fn_t  to ALU
- alu_funct7  out  funct7_t  to ALU
- alu_a, alu_b  out  WIDTH  to ALU
- alu_out  in  WIDTH  from ALU

Behaviour:
- One clock; reset is synchronous, active-low (rst_n sampled on rising clk edge).
- Reset values:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - alu_fn=ADD_SUB, alu_funct7=0, alu_a=0, alu_b=0.
  - result register=0, rsp0_valid=rsp1_valid=0.
  - req*_ready=0 while rst_n=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester 0 if only req0_valid; requester 1 if only req1_valid.
  - If both are valid, grant = !last_grant.
  - reqX_ready = (state==IDLE) & (grant==X), combinational. Never assert both readies.
  - On handshake: latch fn, funct7, a, b into the ALU drive registers; record owner=grant; last_grant<=grant; go to EXEC.
  - No valid: stay in IDLE, ALU drive registers hold their values.
- Shift masking: when the latched fn is SLL or SRL_SRA, alu_b = {0, b[SHAMT_W-1:0]}; otherwise alu_b = b unmodified.
- EXEC: one cycle. result register <= alu_out at cycle end; go to RESP. ALU drive registers are stable for the whole cycle.
- RESP:
  - rsp{owner}_valid=1, rsp{owner}_data=result. The other response valid stays 0.
  - Hold valid and data stable until rsp{owner}_ready=1, then go to IDLE.
  - New requests are not accepted in RESP, even in the handshake cycle.
- Latency: request handshake at edge T → rsp_valid high from cycle T+2. Minimum spacing between accepts is 3 cycles.
- rsp_ready while rsp_valid=0 is ignored.
- Requesters hold valid and payload stable until ready. A valid dropped without handshake causes no state change.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is produced, all registers return to reset values next cycle.
- Arithmetic: wrap-around modulo 2^WIDTH is the ALU's behaviour. The arbiter does not modify results.

Test Plan:
- Reset then req0 {ADD_SUB, funct7=0, a=5, b=7} → req0_ready=1 in cycle 0; alu_a=5, alu_b=7 in cycle 1; rsp0_valid=1, rsp0_data=12 in cycle 2; rsp1_valid=0 throughout.
- Both valid continuously: req0 SUB (funct7=SUB_SRA) 10−3, req1 XOR 0xF0^0xFF, rsp_ready=1 → grant order 0,1,0,1. Results 7, 0x0F, 7, 0x0F. Accepts exactly 3 cycles apart.
- req1 SLL a=1, b=0x0000_0024 (WIDTH=32) → alu_b=4, rsp1_data=16.
- Backpressure: rsp0_ready=0 for 5 cycles after rsp0_valid rises → rsp0_valid and rsp0_data stay stable; req1_ready=0 during this time despite req1_valid=1. Raising rsp0_ready gives IDLE next cycle, then req1 is granted.
- Assert rst_n=0 during EXEC of an ADD 0xFFFF_FFFF+1 → no rsp*_valid ever asserted; after release, outputs are at reset values and the next tie goes to requester 0.
- Wrap case: ADD 0xFFFF_FFFF+1 without reset → rsp0_data=0.
